mem_scan_reader: RTL and testbench

- Sequential front end that walks the inferred byte memory one address at a time and feeds the div3 → hex_to_sseg → disp_mux display path.
- Issues read addresses with write-enable held low, absorbs the one-cycle synchronous read latency, and latches each byte.
- Holds each byte stable for a programmable dwell time, then advances, wrapping at a configurable last address.
- Replaces the constant address/write-enable tie-offs in the top level.

---
 rtl/mem_scan_reader.sv | 108 ++++++++++
 tb/tb_mem_scan_reader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_scan_reader.sv
// Scans a synchronous-read byte memory address by address and holds each byte for DWELL cycles.
// Optional macro SCAN_SKIP_ZERO_EN: zero bytes are skipped without capture or dwell.
module mem_scan_reader #(
    parameter int unsigned          ADDR_W    = 16,
    parameter int unsigned          DATA_W    = 8,
    parameter logic [ADDR_W-1:0]    LAST_ADDR = 16'h000F,
    parameter int unsigned          DWELL     = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              restart,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_do,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [ADDR_W-1:0] cur_addr
);

    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StHold} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              valid_q, valid_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_next;

    assign addr_next  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
    assign mem_addr   = addr_q;
    assign mem_we     = 1'b0;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign cur_addr   = cur_addr_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        cur_addr_d = cur_addr_q;
        valid_d    = 1'b0;
        cnt_d      = cnt_q;

        if (restart) begin
            // Pending pulse is dropped; captured byte stays on display.
            addr_d  = '0;
            state_d = enable ? StIssue : StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable) state_d = StIssue;
                end
                StIssue: begin
                    state_d = StCapture;
                end
                StCapture: begin
`ifdef SCAN_SKIP_ZERO_EN
                    if (mem_do == '0) begin
                        addr_d  = addr_next;
                        state_d = enable ? StIssue : StIdle;
                    end else begin
                        data_d     = mem_do;
                        cur_addr_d = addr_q;
                        valid_d    = 1'b1;
                        cnt_d      = '0;
                        state_d    = StHold;
                    end
`else
                    data_d     = mem_do;
                    cur_addr_d = addr_q;
                    valid_d    = 1'b1;
                    cnt_d      = '0;
                    state_d    = StHold;
`endif
                end
                StHold: begin
                    cnt_d = cnt_q + 32'd1;
                    if (cnt_q == DWELL - 1) begin
                        addr_d  = addr_next;
                        state_d = enable ? StIssue : StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            data_q     <= '0;
            cur_addr_q <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cur_addr_q <= cur_addr_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_scan_reader.sv
// Directed bench for mem_scan_reader with DWELL = 4, LAST_ADDR = 3 and a 4-byte sync-read memory.
module tb_mem_scan_reader;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        restart;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_do;
    logic [7:0]  data_out;
    logic        data_valid;
    logic [15:0] cur_addr;

    logic [7:0]  mem [4];
    int          n_checks;
    int          n_errors;
    int          n;
    int          pulses;

    mem_scan_reader #(
        .ADDR_W    (16),
        .DATA_W    (8),
        .LAST_ADDR (16'd3),
        .DWELL     (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .restart    (restart),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_do     (mem_do),
        .data_out   (data_out),
        .data_valid (data_valid),
        .cur_addr   (cur_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_do <= mem[mem_addr[1:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advances edge by edge until data_valid is seen; returns edges taken.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (data_valid) break;
        end
        if (!data_valid) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_byte(input string tag, input int period, input logic [7:0] d,
                               input logic [15:0] a);
        wait_valid(n);
        check({tag, "_period"}, n, period);
        check({tag, "_data"}, {24'd0, data_out}, {24'd0, d});
        check({tag, "_addr"}, {16'd0, cur_addr}, {16'd0, a});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        mem[0] = 8'h12;
        mem[1] = 8'h00;
        mem[2] = 8'hED;
        mem[3] = 8'h7F;
        reset   = 1'b0;
        enable  = 1'b0;
        restart = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_data", {24'd0, data_out}, 32'd0);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_cur", {16'd0, cur_addr}, 32'd0);
        check("rst_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);

`ifndef SCAN_SKIP_ZERO_EN
        // Latency: stay idle one edge, then raise enable.
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_valid", {31'd0, data_valid}, 32'd0);
        enable = 1'b1;
        @(posedge clk);
        #1;
        check("issue_addr", {16'd0, mem_addr}, 32'd0);
        check("issue_valid", {31'd0, data_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("capture_valid", {31'd0, data_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_valid", {31'd0, data_valid}, 32'd1);
        check("lat_data", {24'd0, data_out}, 32'h12);
        @(posedge clk);
        #1;
        check("pulse_width", {31'd0, data_valid}, 32'd0);

        expect_byte("scan1", 5, 8'h00, 16'd1);
        expect_byte("scan2", 6, 8'hED, 16'd2);
        expect_byte("scan3", 6, 8'h7F, 16'd3);
        expect_byte("scan_wrap", 6, 8'h12, 16'd0);
        check("we_low", {31'd0, mem_we}, 32'd0);

        // Restart lands on the last HOLD edge of address 1.
        expect_byte("pre_rst", 6, 8'h00, 16'd1);
        repeat (3) @(posedge clk);
        #1;
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        check("rs_addr", {16'd0, mem_addr}, 32'd0);
        check("rs_valid", {31'd0, data_valid}, 32'd0);
        check("rs_keep_data", {24'd0, data_out}, 32'h00);
        check("rs_keep_cur", {16'd0, cur_addr}, 32'd1);
        expect_byte("post_rst", 2, 8'h12, 16'd0);

        // Enable dropped in the HOLD of address 2.
        expect_byte("en_a1", 6, 8'h00, 16'd1);
        expect_byte("en_a2", 6, 8'hED, 16'd2);
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("en_idle_addr", {16'd0, mem_addr}, 32'd3);
        check("en_keep_data", {24'd0, data_out}, 32'hED);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (data_valid) pulses++;
        end
        check("en_no_pulse", pulses, 32'd0);
        check("en_still_addr", {16'd0, mem_addr}, 32'd3);
        enable = 1'b1;
        expect_byte("en_resume", 3, 8'h7F, 16'd3);

        // Async reset in CAPTURE of address 2.
        expect_byte("ar_a0", 6, 8'h12, 16'd0);
        expect_byte("ar_a1", 6, 8'h00, 16'd1);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("ar_data", {24'd0, data_out}, 32'd0);
        check("ar_valid", {31'd0, data_valid}, 32'd0);
        check("ar_cur", {16'd0, cur_addr}, 32'd0);
        check("ar_addr", {16'd0, mem_addr}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        expect_byte("ar_resume", 3, 8'h12, 16'd0);
`else
        reset  = 1'b1;
        enable = 1'b1;
        expect_byte("sz_a0", 3, 8'h12, 16'd0);
        expect_byte("sz_a2", 8, 8'hED, 16'd2);
        expect_byte("sz_a3", 6, 8'h7F, 16'd3);
        expect_byte("sz_wrap", 6, 8'h12, 16'd0);
        expect_byte("sz_a2b", 8, 8'hED, 16'd2);
        check("sz_we", {31'd0, mem_we}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
